// File: rtl/vault_alarm_pkg.sv
// Shared types, default parameters and the violation rule for the vault alarm controller.
package vault_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRACE = 2'd1,
    ALARM = 2'd2
  } vault_state_t;

  localparam int DEF_NVAULTS      = 4;
  localparam int DEF_GRACE_CYCLES = 3;
  localparam int DEF_TONE_DIV     = 2;
  localparam int DEF_CNT_BITS     = 8;

  // An open door is legal only during business hours with the manager switch off.
  function automatic logic violation(input logic door, input logic hours, input logic mgr);
    return door & ~(hours & ~mgr);
  endfunction

endpackage

// File: rtl/vault_channel_fsm.sv
// One vault channel: IDLE/GRACE/ALARM state machine with a grace-delay timer.
module vault_channel_fsm
  import vault_alarm_pkg::*;
#(
  parameter int GRACE_CYCLES = DEF_GRACE_CYCLES
) (
  input  logic clk_2,
  input  logic reset,
  input  logic violation_i,
  input  logic door_open,
  input  logic ack,
  output logic alarm,
  output logic grace,
  output logic alarm_next,
  output logic enter_alarm
);

  localparam int TW = (GRACE_CYCLES < 2) ? 1 : $clog2(GRACE_CYCLES + 1);
  localparam logic [TW-1:0] GRACE_LOAD = (GRACE_CYCLES == 0) ? '0 : TW'(GRACE_CYCLES - 1);

  vault_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          alarm_q, alarm_d;
  logic          grace_q, grace_d;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      alarm_q <= 1'b0;
      grace_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      alarm_q <= alarm_d;
      grace_q <= grace_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (violation_i) begin
          if (GRACE_CYCLES == 0) begin
            state_d = ALARM;
          end else begin
            state_d = GRACE;
            timer_d = GRACE_LOAD;
          end
        end
      end
      GRACE: begin
        if (!violation_i) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = ALARM;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      // Only an acknowledge with the door shut releases a latched alarm.
      ALARM: begin
        if (ack && !door_open) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    alarm_d     = (state_d == ALARM);
    grace_d     = (state_d == GRACE);
    enter_alarm = alarm_d && (state_q != ALARM);
  end

  assign alarm      = alarm_q;
  assign grace      = grace_q;
  assign alarm_next = alarm_d;

endmodule

// File: rtl/vault_alarm_ctrl.sv
// Multi-vault alarm controller: per-vault channels plus shared siren divider and event counter.
module vault_alarm_ctrl
  import vault_alarm_pkg::*;
#(
  parameter int NVAULTS      = DEF_NVAULTS,
  parameter int GRACE_CYCLES = DEF_GRACE_CYCLES,
  parameter int TONE_DIV     = DEF_TONE_DIV,
  parameter int CNT_BITS     = DEF_CNT_BITS
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [NVAULTS-1:0]  door_open,
  input  logic                business_hours,
  input  logic                mgr_switch,
  input  logic                ack,
  output logic [NVAULTS-1:0]  alarm,
  output logic [NVAULTS-1:0]  grace,
  output logic                siren,
  output logic [CNT_BITS-1:0] alarm_count
);

  localparam int DW = (TONE_DIV < 3) ? 1 : $clog2(TONE_DIV);
  localparam logic [DW-1:0] DIV_LAST = (TONE_DIV == 0) ? '0 : DW'(TONE_DIV - 1);
  localparam int SW = CNT_BITS + 5;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_BITS{1'b1}});

  logic [NVAULTS-1:0] vio;
  logic [NVAULTS-1:0] alarm_next;
  logic [NVAULTS-1:0] enter_alarm;

  for (genvar i = 0; i < NVAULTS; i++) begin : g_chan
    assign vio[i] = violation(door_open[i], business_hours, mgr_switch);

    vault_channel_fsm #(
      .GRACE_CYCLES(GRACE_CYCLES)
    ) u_chan (
      .clk_2       (clk_2),
      .reset       (reset),
      .violation_i (vio[i]),
      .door_open   (door_open[i]),
      .ack         (ack),
      .alarm       (alarm[i]),
      .grace       (grace[i]),
      .alarm_next  (alarm_next[i]),
      .enter_alarm (enter_alarm[i])
    );
  end

  logic          siren_q, siren_d;
  logic [DW-1:0] div_q, div_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [3:0]    enter_cnt;
  logic [SW-1:0] sum;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      siren_q <= 1'b0;
      div_q   <= '0;
      count_q <= '0;
    end else begin
      siren_q <= siren_d;
      div_q   <= div_d;
      count_q <= count_d;
    end
  end

  // Siren restarts high on a fresh alarm, then toggles each time the divider wraps.
  always_comb begin
    siren_d = siren_q;
    div_d   = div_q;
    if (!(|alarm_next)) begin
      siren_d = 1'b0;
      div_d   = '0;
    end else if (!(|alarm)) begin
      siren_d = 1'b1;
      div_d   = '0;
    end else if (TONE_DIV == 0) begin
      siren_d = 1'b1;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      siren_d = ~siren_q;
      div_d   = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_comb begin
    enter_cnt = '0;
    for (int i = 0; i < NVAULTS; i++) begin
      enter_cnt = enter_cnt + {3'b000, enter_alarm[i]};
    end
    sum     = SW'(count_q) + SW'(enter_cnt);
    count_d = (sum > CNT_MAX) ? CNT_MAX[CNT_BITS-1:0] : sum[CNT_BITS-1:0];
  end

  assign siren       = siren_q;
  assign alarm_count = count_q;

endmodule
